// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for load-use, branch and mul/div hazards
module pipeline_hazard_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_Rt,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             IFID_UsesRt,
   input  logic             BranchTaken,
   input  logic             MulDivStart,
   input  logic             MulDivDone,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXWrite,
   output logic             IFIDFlush,
   output logic             IDEXFlush,
   output logic             EXMEMFlush,
   output logic             McTimeout,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam int WCW = $clog2(MC_TIMEOUT + 1);

   typedef enum logic {RUN, MC_WAIT} state_t;

   state_t           state_q, state_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic             mc_timeout_q, mc_timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use;
   logic             flush_evt;

   assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                     ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

   assign McTimeout  = mc_timeout_q;
   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

   // Next-state and zero-latency control outputs; reset forces everything frozen and flushed.
   always_comb begin
      PCWrite      = 1'b1;
      IFIDWrite    = 1'b1;
      IDEXWrite    = 1'b1;
      IFIDFlush    = 1'b0;
      IDEXFlush    = 1'b0;
      EXMEMFlush   = 1'b0;
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      mc_timeout_d = mc_timeout_q;
      flush_evt    = 1'b0;

      if (!Reset) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEXWrite  = 1'b0;
         IFIDFlush  = 1'b1;
         IDEXFlush  = 1'b1;
         EXMEMFlush = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (BranchTaken) begin
                  // The younger instruction in ID is squashed, so any load-use on it is moot.
                  IFIDFlush = 1'b1;
                  IDEXFlush = 1'b1;
                  flush_evt = 1'b1;
               end else if (MulDivStart && !MulDivDone) begin
                  PCWrite    = 1'b0;
                  IFIDWrite  = 1'b0;
                  IDEXWrite  = 1'b0;
                  EXMEMFlush = 1'b1;
                  state_d    = MC_WAIT;
                  wait_cnt_d = WCW'(1);
               end else if (MulDivStart && MulDivDone) begin
                  state_d = RUN;
               end else if (load_use) begin
                  // Bubble enters ID/EX and clears IDEX_MemRead, so this lasts one cycle.
                  PCWrite   = 1'b0;
                  IFIDWrite = 1'b0;
                  IDEXFlush = 1'b1;
               end
            end
            MC_WAIT: begin
               if (MulDivDone) begin
                  state_d    = RUN;
                  wait_cnt_d = '0;
               end else if (wait_cnt_q == WCW'(MC_TIMEOUT)) begin
                  state_d      = RUN;
                  wait_cnt_d   = '0;
                  mc_timeout_d = 1'b1;
               end else begin
                  PCWrite    = 1'b0;
                  IFIDWrite  = 1'b0;
                  IDEXWrite  = 1'b0;
                  EXMEMFlush = 1'b1;
                  wait_cnt_d = wait_cnt_q + WCW'(1);
               end
            end
            default: begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end
         endcase
      end
   end

   // Saturating statistics; reset cycles are not counted.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (Reset && !PCWrite && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}}))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // State, wait counter, sticky timeout flag and statistics registers.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q      <= RUN;
         wait_cnt_q   <= '0;
         mc_timeout_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         mc_timeout_q <= mc_timeout_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   // {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush}
   localparam logic [5:0] NORM = 6'b111_000;
   localparam logic [5:0] RST  = 6'b000_111;
   localparam logic [5:0] LU   = 6'b001_010;
   localparam logic [5:0] BR   = 6'b111_110;
   localparam logic [5:0] MC   = 6'b000_001;

   logic        Clk;
   logic        Reset;
   logic        IDEX_MemRead;
   logic [4:0]  IDEX_Rt;
   logic [4:0]  IFID_Rs;
   logic [4:0]  IFID_Rt;
   logic        IFID_UsesRt;
   logic        BranchTaken;
   logic        MulDivStart;
   logic        MulDivDone;

   logic        pcw1, ifw1, idw1, iff1, idf1, exf1, mct1;
   logic [15:0] stall1, flush1;
   logic        pcw2, ifw2, idw2, iff2, idf2, exf2, mct2;
   logic [2:0]  stall2, flush2;

   logic [5:0]  ctrl1, ctrl2;
   assign ctrl1 = {pcw1, ifw1, idw1, iff1, idf1, exf1};
   assign ctrl2 = {pcw2, ifw2, idw2, iff2, idf2, exf2};

   typedef struct {
      string      tag;
      logic [5:0] exp;
      bit         which;
   } exp_t;

   exp_t sb[$];
   int   n_asserts = 0;
   int   n_fail    = 0;

   pipeline_hazard_ctrl u_dut (
      .Clk(Clk), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
      .BranchTaken(BranchTaken), .MulDivStart(MulDivStart), .MulDivDone(MulDivDone),
      .PCWrite(pcw1), .IFIDWrite(ifw1), .IDEXWrite(idw1), .IFIDFlush(iff1),
      .IDEXFlush(idf1), .EXMEMFlush(exf1), .McTimeout(mct1),
      .StallCount(stall1), .FlushCount(flush1)
   );

   pipeline_hazard_ctrl #(.MC_TIMEOUT(4), .CNT_W(3)) u_dut_to (
      .Clk(Clk), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
      .BranchTaken(BranchTaken), .MulDivStart(MulDivStart), .MulDivDone(MulDivDone),
      .PCWrite(pcw2), .IFIDWrite(ifw2), .IDEXWrite(idw2), .IFIDFlush(iff2),
      .IDEXFlush(idf2), .EXMEMFlush(exf2), .McTimeout(mct2),
      .StallCount(stall2), .FlushCount(flush2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // One clock step: expectation queued with the stimulus, popped and checked at negedge.
   task automatic cyc(input string tag, input logic [5:0] exp, input bit which);
      exp_t       e;
      logic [5:0] obs;
      e.tag = tag;
      e.exp = exp;
      e.which = which;
      sb.push_back(e);
      @(negedge Clk);
      e = sb.pop_front();
      obs = e.which ? ctrl2 : ctrl1;
      n_asserts++;
      assert (obs === e.exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr_lu();
      IDEX_MemRead = 1'b0;
      IDEX_Rt      = 5'd0;
      IFID_Rs      = 5'd0;
      IFID_Rt      = 5'd0;
      IFID_UsesRt  = 1'b0;
   endtask

   initial begin
      Reset = 1'b0;
      clr_lu();
      BranchTaken = 1'b0;
      MulDivStart = 1'b0;
      MulDivDone  = 1'b0;
      @(posedge Clk);
      #1;

      // Reset behaviour
      cyc("rst_a", RST, 0);
      cyc("rst_b", RST, 1);
      Reset = 1'b1;
      chk("rst_stall", stall1, 16'd0);
      chk("rst_flush", flush1, 16'd0);
      chk("rst_mct", {15'd0, mct1}, 16'd0);
      cyc("idle", NORM, 0);

      // Load-use on rs, and the $0 exemption
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
      cyc("lu_rs", LU, 0);
      clr_lu();
      cyc("lu_clear", NORM, 0);
      chk("lu_stall", stall1, 16'd1);
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
      cyc("lu_r0", NORM, 0);
      chk("lu_r0_stall", stall1, 16'd1);

      // Load-use on rt gated by UsesRt
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd3; IFID_Rt = 5'd8; IFID_UsesRt = 1'b0;
      cyc("lu_rt_unused", NORM, 0);
      IFID_UsesRt = 1'b1;
      cyc("lu_rt_used", LU, 0);
      clr_lu();
      chk("lu_rt_stall", stall1, 16'd2);

      // Branch beats load-use
      IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8; BranchTaken = 1'b1;
      cyc("br_lu", BR, 0);
      clr_lu();
      BranchTaken = 1'b0;
      chk("br_flushcnt", flush1, 16'd1);
      chk("br_stall", stall1, 16'd2);

      // Mul/div: 5 stall cycles, branch/load-use ignored while waiting, release on Done
      MulDivStart = 1'b1;
      cyc("md_0", MC, 0);
      cyc("md_1", MC, 0);
      BranchTaken = 1'b1; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
      cyc("md_2_br", MC, 0);
      BranchTaken = 1'b0; clr_lu();
      cyc("md_3", MC, 0);
      cyc("md_4", MC, 0);
      MulDivDone = 1'b1;
      cyc("md_done", NORM, 0);
      MulDivStart = 1'b0; MulDivDone = 1'b0;
      cyc("md_after", NORM, 0);
      chk("md_stall", stall1, 16'd7);
      chk("md_flushcnt", flush1, 16'd1);
      chk("md_mct", {15'd0, mct1}, 16'd0);

      // Timeout instance: fresh start
      Reset = 1'b0;
      cyc("to_rst", RST, 1);
      Reset = 1'b1;
      MulDivStart = 1'b1;
      for (int i = 0; i < 4; i++) cyc("to_stall", MC, 1);
      cyc("to_release", NORM, 1);
      chk("to_mct", {15'd0, mct2}, 16'd1);
      chk("to_stall_cnt", {13'd0, stall2}, 16'd4);
      MulDivStart = 1'b0;
      cyc("to_idle", NORM, 1);
      chk("to_mct_sticky", {15'd0, mct2}, 16'd1);

      // Second timeout drives StallCount past 3-bit saturation
      MulDivStart = 1'b1;
      for (int i = 0; i < 4; i++) cyc("sat_stall", MC, 1);
      cyc("sat_release", NORM, 1);
      MulDivStart = 1'b0;
      chk("sat_stall_cnt", {13'd0, stall2}, 16'd7);

      // Reset in the middle of MC_WAIT returns to RUN and clears sticky flag
      MulDivStart = 1'b1;
      cyc("mid_0", MC, 1);
      cyc("mid_1", MC, 1);
      chk("mid_mct_pre", {15'd0, mct2}, 16'd1);
      Reset = 1'b0;
      cyc("mid_rst", RST, 1);
      Reset = 1'b1;
      MulDivStart = 1'b0;
      cyc("mid_run", NORM, 1);
      chk("mid_mct", {15'd0, mct2}, 16'd0);
      chk("mid_stall", {13'd0, stall2}, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
